// File: rtl/alu_control_transfer_pkg.sv
// Shared definitions for the RV32I control-transfer unit: op encodings,
// branch funct3 values and the default-width result record.
package alu_control_transfer_pkg;

  localparam int CT_XLEN = 32;

  localparam logic [3:0] OP_JAL           = 4'b0000;
  localparam logic [3:0] OP_JALR          = 4'b0001;
  localparam logic       OP_BRANCH_PREFIX = 1'b1;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [CT_XLEN-1:0] rd_value;
    logic               rd_write;
    logic [CT_XLEN-1:0] next_pc;
    logic               redirect;
    logic               illegal;
  } ct_result_t;

  // funct3 010/011 have no branch meaning in RV32I
  function automatic logic f3_is_branch(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/alu_control_transfer_branch_compare.sv
// Combinational branch taken decision from funct3 and the two operands.
// Kept standalone so a predictor check can reuse the same compare.
module alu_branch_compare
  import alu_control_transfer_pkg::*;
#(
  parameter int XLEN = CT_XLEN
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            taken_o
);

  // Signed compare for BLT/BGE, unsigned for BLTU/BGEU
  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = (rs1_i == rs2_i);
      F3_BNE:  taken_o = (rs1_i != rs2_i);
      F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
      F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      F3_BLTU: taken_o = (rs1_i <  rs2_i);
      F3_BGEU: taken_o = (rs1_i >= rs2_i);
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_control_transfer.sv
// RV32I control-transfer unit (JAL, JALR, branches): two-stage valid/ready
// pipeline producing link value, next PC and redirect.
// Optional: ALU_CONTROL_TRANSFER_MISALIGN_TRAP_EN adds the misaligned output
// and suppresses redirect/link write for misaligned taken targets.
module alu_control_transfer
  import alu_control_transfer_pkg::*;
#(
  parameter int XLEN        = CT_XLEN,
  parameter int IALIGN      = 32,
  parameter int LINK_OFFSET = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [XLEN-1:0] immediate,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_value,
  output logic            rd_write,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
`ifdef ALU_CONTROL_TRANSFER_MISALIGN_TRAP_EN
  output logic            misaligned,
`endif
  output logic            illegal
);

  localparam logic [XLEN-1:0] LINK_INC = XLEN'(LINK_OFFSET);

  typedef struct packed {
    logic [XLEN-1:0] rd_value;
    logic            rd_write;
    logic [XLEN-1:0] next_pc;
    logic            redirect;
    logic            illegal;
  } res_t;

  logic            a_valid_q, b_valid_q;
  logic [3:0]      a_op_q;
  logic [XLEN-1:0] a_pc_q, a_rs1_q, a_rs2_q, a_imm_q;
  res_t            res_d, res_q;
  logic            a_adv, in_fire;
  logic            is_jal, is_jalr, is_br, br_taken, taken, tgt_misaligned;
  logic [XLEN-1:0] target_sum, target, link;

  // Stage A may move on whenever stage B is empty or being drained
  assign a_adv    = !b_valid_q || out_ready;
  assign in_ready = !a_valid_q || a_adv;
  assign in_fire  = in_valid && in_ready && !flush;

  // Stage A: capture accepted operands
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_valid_q <= 1'b0;
      a_op_q    <= '0;
      a_pc_q    <= '0;
      a_rs1_q   <= '0;
      a_rs2_q   <= '0;
      a_imm_q   <= '0;
    end else begin
      if (flush)         a_valid_q <= 1'b0;
      else if (in_ready) a_valid_q <= in_valid;
      if (in_fire) begin
        a_op_q  <= op;
        a_pc_q  <= pc;
        a_rs1_q <= rs1_value;
        a_rs2_q <= rs2_value;
        a_imm_q <= immediate;
      end
    end
  end

  assign is_jal     = (a_op_q == OP_JAL);
  assign is_jalr    = (a_op_q == OP_JALR);
  assign is_br      = (a_op_q[3] == OP_BRANCH_PREFIX) && f3_is_branch(a_op_q[2:0]);
  assign target_sum = (is_jalr ? a_rs1_q : a_pc_q) + a_imm_q;
  assign target     = {target_sum[XLEN-1:1], target_sum[0] & !is_jalr};
  assign link       = a_pc_q + LINK_INC;
  assign taken      = is_jal || is_jalr || (is_br && br_taken);
  // 16-bit alignment never faults for even targets
  assign tgt_misaligned = (IALIGN == 32) && target[1];

  alu_branch_compare #(.XLEN(XLEN)) u_cmp (
    .funct3_i (a_op_q[2:0]),
    .rs1_i    (a_rs1_q),
    .rs2_i    (a_rs2_q),
    .taken_o  (br_taken)
  );

`ifdef ALU_CONTROL_TRANSFER_MISALIGN_TRAP_EN
  logic mis_d, mis_q;
  assign misaligned = mis_q;
`else
  logic unused_misalign;
  assign unused_misalign = tgt_misaligned;
`endif

  // Result formation; misaligned taken targets become a trap carrying the target
  always_comb begin
    res_d.rd_value = link;
    res_d.rd_write = is_jal || is_jalr;
    res_d.next_pc  = taken ? target : link;
    res_d.redirect = taken;
    res_d.illegal  = !(is_jal || is_jalr || is_br);
`ifdef ALU_CONTROL_TRANSFER_MISALIGN_TRAP_EN
    mis_d = 1'b0;
    if (taken && tgt_misaligned) begin
      mis_d          = 1'b1;
      res_d.redirect = 1'b0;
      res_d.rd_write = 1'b0;
    end
`endif
  end

  // Stage B: result register, held while the consumer stalls
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      b_valid_q <= 1'b0;
      res_q     <= '0;
`ifdef ALU_CONTROL_TRANSFER_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      if (flush)      b_valid_q <= 1'b0;
      else if (a_adv) b_valid_q <= a_valid_q;
      if (a_adv && a_valid_q) begin
        res_q <= res_d;
`ifdef ALU_CONTROL_TRANSFER_MISALIGN_TRAP_EN
        mis_q <= mis_d;
`endif
      end
    end
  end

  assign out_valid = b_valid_q;
  assign rd_value  = res_q.rd_value;
  assign rd_write  = res_q.rd_write;
  assign next_pc   = res_q.next_pc;
  assign redirect  = res_q.redirect;
  assign illegal   = res_q.illegal;

endmodule

// File: doc/alu_control_transfer.md
Name: alu_control_transfer

Overview:
Parametrised successor to the single-purpose JALR unit. One block executes every RV32I control-transfer instruction: JAL, JALR, BEQ, BNE, BLT, BGE, BLTU and BGEU. It produces the link value, the next PC and a redirect flag. It is a 2-stage valid/ready pipeline between decode/operand-read and the PC-update/writeback logic, with backpressure and flush.

Parameters:
XLEN, 32, datapath width for pc, operands, immediate and results.
IALIGN, 32, instruction alignment in bits (32 or 16); sets the target-misalignment check.
LINK_OFFSET, 4, byte increment added to pc for the link value and the not-taken PC.

Ports:
clock  in  1  rising-edge clock.
reset_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous kill of all in-flight operations.
in_valid  in  1  operation offered.
in_ready  out  1  block accepts the operation this cycle.
op  in  4  operation code (see Behaviour).
pc  in  XLEN  address of the instruction.
rs1_value  in  XLEN  register source 1.
rs2_value  in  XLEN  register source 2 (branches only).
immediate  in  XLEN  sign-extended J/I/B immediate, already in byte units.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
rd_value  out  XLEN  link value (pc + LINK_OFFSET).
rd_write  out  1  1 for JAL/JALR, 0 otherwise.
next_pc  out  XLEN  PC of the next instruction.
redirect  out  1  control flow leaves the sequential path.
illegal  out  1  op is not a defined encoding.

Behaviour:
- Reset: async assert clears both stage valids immediately. Outputs on reset: out_valid=0, rd_value=0, rd_write=0, next_pc=0, redirect=0, illegal=0. in_ready=1 after reset is released.
- op encoding: 4'b0000 JAL; 4'b0001 JALR; 4'b1fff branch, where fff is the RV funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU). All other codes are illegal.
- Stage A (execute): registers the handshake-accepted inputs. It computes:
  - target = base + immediate, modulo 2^XLEN, with base = rs1_value for JALR and pc otherwise.
  - For JALR, target bit 0 is forced to 0.
  - The branch condition: signed compare for BLT/BGE, unsigned for BLTU/BGEU.
- Stage B (result): registers next_pc, rd_value, rd_write, redirect and illegal.
  - next_pc = target if taken (JAL/JALR always taken), else pc + LINK_OFFSET.
  - redirect = taken.
- Latency: 2 cycles from input acceptance to out_valid with no stall. Throughput is 1 operation per cycle.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - in_ready = !a_valid | !b_valid | out_ready. The pipeline advances whenever the downstream slot is free or draining.
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - Order is strictly preserved; nothing is dropped or duplicated.
- Illegal op: passes through the pipeline with illegal=1, redirect=0, rd_write=0, next_pc=pc+LINK_OFFSET, rd_value=pc+LINK_OFFSET.
- flush:
  - Clears a_valid and b_valid on the next edge.
  - An input offered in the same cycle as flush is discarded, even though in_ready=1.
  - out_valid=0 the cycle after flush.
- Reset mid-operation: all in-flight operations are lost; no partial output.
- Wrap-around: pc=0xFFFFFFFC gives link value 0x00000000; the target wraps the same way. Neither is flagged.
- Data registers are not cleared by flush, only the valids.

Optional Feature:
Macro ALU_CONTROL_TRANSFER_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned (1 bit), which resets to 0.
  - For a taken transfer whose target is not IALIGN-aligned (target[1] set when IALIGN=32; never when IALIGN=16), misaligned=1, redirect=0, rd_write=0.
  - next_pc carries the faulting target for the trap handler (mtval).
- Undefined: no misaligned port; taken transfers redirect regardless of alignment.

Decomposition:
- Shared package: XLEN default, the op encoding constants (OP_JAL, OP_JALR, OP_BRANCH_PREFIX, the funct3 values) and a result struct {rd_value, rd_write, next_pc, redirect, illegal}.
- One natural sub-module, alu_branch_compare: a combinational taken-decision from funct3, rs1 and rs2. It is reused by a future branch predictor check.

Test Plan:
- JALR, pc=0x100, rs1=0x2003, imm=0x4 -> two cycles later next_pc=0x2006, rd_value=0x104, rd_write=1, redirect=1.
- BLT vs BLTU, rs1=0xFFFFFFFF, rs2=0x1, pc=0x40, imm=0x20:
  - BLT -> taken, next_pc=0x60, redirect=1.
  - BLTU -> next_pc=0x44, redirect=0, rd_write=0.
- Backpressure: hold out_ready=0 and offer 3 back-to-back JALs (pc 0x0/0x4/0x8, imm 0x10):
  - Two are accepted, then in_ready=0 and the third is held.
  - Release out_ready -> results 0x10, 0x14, 0x18 appear in order, outputs stable while stalled.
- flush with two ops in flight plus one offered -> out_valid=0 the next cycle, no result from any of the three; the next op completes normally.
- Illegal op 4'b1010 and op 4'b0011 -> illegal=1, redirect=0, rd_write=0, next_pc=pc+4.
- Macro defined, IALIGN=32: JAL pc=0x0, imm=0x6 -> misaligned=1, redirect=0, next_pc=0x6. Assert reset_n low mid-stream -> out_valid=0 immediately, all outputs 0.
